hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised successor to the single-load-use interlock. It tracks every outstanding long-latency register write (loads, multi-cycle ALU ops) in a per-register pending bitmap. It stalls decode on RAW and WAW hazards against that bitmap, and stalls when the in-flight limit is reached. It sits between ID and EX, drives the PC/IF-ID write enables and the ID/EX bubble, and accepts completion notices from writeback.

## Interface
- REG_AW, 5: register index width; NUM_REGS = 2**REG_AW.
- NUM_SRC, 2: number of source operands checked per instruction (3 for fused ops).
- MAX_INFLIGHT, 4: maximum long-latency ops outstanding; ≥1.
- FWD_FROM_WB, 1: 1 = a writeback completing this cycle is bypassed and does not stall; 0 = it stalls one extra cycle.
- CNT_W, 16: width of the stall-cycle performance counter.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a valid instruction.
- id_rs  in  NUM_SRC*REG_AW  source indices; operand k occupies bits [k*REG_AW +: REG_AW].
- id_rs_used  in  NUM_SRC  per-operand "source actually read" flag.
- id_rd  in  REG_AW  destination index.
- id_long  in  1  ID instruction is long-latency (load, div, mul-multicycle).
- wb_valid  in  1  a long-latency op completes its register write this cycle.
- wb_rd  in  REG_AW  destination of the completing op.
- flush  in  1  squash the ID instruction (branch redirect).
- stall  out  1  hold PC and IF/ID.
- pc_write  out  1  equals ~stall.
- if_id_write  out  1  equals ~stall.
- id_ex_bubble  out  1  inject NOP into ID/EX; equals stall | flush.
- pending  out  NUM_REGS  registered pending bitmap.
- inflight_cnt  out  $clog2(MAX_INFLIGHT+1)  outstanding long ops.
- proto_err  out  1  sticky protocol-error flag.
- stall_cycles  out  CNT_W  saturating count of cycles with stall=1.

## Operation
- clr[r] = wb_valid & (wb_rd==r) & (r≠0). With FWD_FROM_WB=0, clr is forced to 0 for hazard evaluation only; state update still uses clr.
- busy[r] = pending[r] & ~clr[r]. Register 0 is never busy.
- raw = OR over k of id_rs_used[k] & busy[id_rs[k]].
- waw = id_long & busy[id_rd].
- full = id_long & (inflight_cnt == MAX_INFLIGHT) & ~wb_valid.
- stall = id_valid & ~flush & (raw | waw | full). The stall signals are combinational.
- issue = id_valid & ~flush & ~stall & id_long.
- Next pending = (pending & ~clr) | (issue & id_rd≠0 ? onehot(id_rd) : 0). If set and clear hit the same register, set wins.
- inflight_cnt update: +1 on issue, −1 on wb_valid. Both in the same cycle leaves it unchanged. It never wraps.
- Ops with rd=0 still count toward inflight_cnt; wb_rd=0 decrements it.
- proto_err is set when either of these occurs:
  - wb_valid while inflight_cnt==0 (the decrement is suppressed).
  - wb_valid with wb_rd≠0 and pending[wb_rd]=0.
- proto_err is cleared only by reset.
- stall_cycles increments on every cycle with stall=1 and saturates at all-ones.
- flush does not clear pending or inflight_cnt. Already-issued ops still complete.

## Timing
- Reset (async assert, sync-to-clk release): pending=0, inflight_cnt=0, proto_err=0, stall_cycles=0. Combinational outputs follow the inputs immediately: stall=0 when id_valid=0, so pc_write=if_id_write=1.
- Reset mid-operation discards all tracking. The pipeline is assumed flushed by the same reset.
- Issue in cycle N sets pending in cycle N+1, so a dependent in ID at N+1 stalls.
- Writeback at cycle M:
  - FWD_FROM_WB=1: the dependent proceeds in cycle M.
  - FWD_FROM_WB=0: the dependent stalls in M and proceeds in M+1.
- Full: with MAX_INFLIGHT outstanding, a long op stalls. It issues in the cycle a wb_valid arrives (FWD irrelevant).
- flush and a would-be stall in the same cycle: stall=0, bubble=1, no issue.

## Test plan
- Load-use: issue load rd=5 at cycle 0; an add reading x5 in ID at cycle 1; wb_valid rd=5 at cycle 3 -> stall=1 in cycles 1–2 and 0 in cycle 3 (FWD=1); stall_cycles=2; pending[5]: 1 in cycles 1–3, 0 at cycle 4.
- Same sequence with FWD_FROM_WB=0 -> stall=1 in cycles 1–3; release in cycle 4; stall_cycles=3.
- WAW and x0:
  - Long op rd=7 pending, a second long op rd=7 in ID -> stall until wb rd=7. On that cycle it issues, and pending[7] stays 1 (set wins).
  - A load with rd=0 -> pending stays 0 and inflight_cnt increments.
- Capacity: MAX_INFLIGHT=4; issue 4 loads to x1..x4, a 5th to x9 -> stall=1, inflight_cnt=4. wb rd=1 -> the 5th issues the same cycle and the count stays at 4.
- Flush: a dependent in ID plus flush=1 -> stall=0, id_ex_bubble=1, pc_write=1, pending unchanged, no issue.
- Errors and reset:
  - wb_valid with inflight_cnt=0 -> proto_err=1 and the count stays 0.
  - wb to a non-pending reg -> proto_err=1.
  - Assert rst_n=0 asynchronously mid-stall -> pending, inflight_cnt, proto_err and stall_cycles clear without waiting for a clock edge.
  - Saturation: force 2^CNT_W+3 stall cycles -> stall_cycles holds all-ones.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// ID/WB-side bundle of the hazard scoreboard: decode operands, writeback notices and stall controls.
// master = pipeline (drives ID/WB), slave = scoreboard (drives stall controls and status).
interface hazard_scoreboard_if #(
   parameter int REG_AW       = 5,
   parameter int NUM_SRC      = 2,
   parameter int MAX_INFLIGHT = 4,
   parameter int CNT_W        = 16
);
   localparam int NUM_REGS = 2**REG_AW;
   localparam int IFL_W    = $clog2(MAX_INFLIGHT+1);

   logic                      id_valid;
   logic [NUM_SRC*REG_AW-1:0] id_rs;
   logic [NUM_SRC-1:0]        id_rs_used;
   logic [REG_AW-1:0]         id_rd;
   logic                      id_long;
   logic                      wb_valid;
   logic [REG_AW-1:0]         wb_rd;
   logic                      flush;

   logic                      stall;
   logic                      pc_write;
   logic                      if_id_write;
   logic                      id_ex_bubble;
   logic [NUM_REGS-1:0]       pending;
   logic [IFL_W-1:0]          inflight_cnt;
   logic                      proto_err;
   logic [CNT_W-1:0]          stall_cycles;

   modport master (
      output id_valid, id_rs, id_rs_used, id_rd, id_long, wb_valid, wb_rd, flush,
      input  stall, pc_write, if_id_write, id_ex_bubble, pending, inflight_cnt,
             proto_err, stall_cycles
   );

   modport slave (
      input  id_valid, id_rs, id_rs_used, id_rd, id_long, wb_valid, wb_rd, flush,
      output stall, pc_write, if_id_write, id_ex_bubble, pending, inflight_cnt,
             proto_err, stall_cycles
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register pending scoreboard for long-latency writes; stalls decode on RAW/WAW/capacity hazards.
// Stall controls are combinational (0 cycles); pending/count update one cycle after issue or writeback.
module hazard_scoreboard #(
   parameter int REG_AW       = 5,
   parameter int NUM_SRC      = 2,
   parameter int MAX_INFLIGHT = 4,
   parameter int FWD_FROM_WB  = 1,
   parameter int CNT_W        = 16
) (
   input logic               clk,
   input logic               rst_n,
   hazard_scoreboard_if.slave sb
);
   localparam int NUM_REGS = 2**REG_AW;
   localparam int IFL_W    = $clog2(MAX_INFLIGHT+1);
   localparam logic [IFL_W-1:0] IFL_MAX = IFL_W'(MAX_INFLIGHT);

   logic [NUM_REGS-1:0] pending_q, pending_d;
   logic [IFL_W-1:0]    cnt_q, cnt_d;
   logic                err_q, err_d;
   logic [CNT_W-1:0]    stc_q, stc_d;

   logic [NUM_REGS-1:0] clr, clr_haz, busy, set_vec;
   logic raw, waw, full, stall, issue, wb_underflow, wb_orphan, wb_dec;

   always_comb begin
      clr = '0;
      if (sb.wb_valid && sb.wb_rd != '0) clr[sb.wb_rd] = 1'b1;
   end

   // Without WB bypass the completing register still looks busy this cycle.
   assign clr_haz = (FWD_FROM_WB != 0) ? clr : '0;
   assign busy    = pending_q & ~clr_haz & ~NUM_REGS'(1);

   always_comb begin
      raw = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (sb.id_rs_used[k] && busy[sb.id_rs[k*REG_AW +: REG_AW]]) raw = 1'b1;
      end
   end

   assign waw   = sb.id_long & busy[sb.id_rd];
   assign full  = sb.id_long & (cnt_q == IFL_MAX) & ~sb.wb_valid;
   assign stall = sb.id_valid & ~sb.flush & (raw | waw | full);
   assign issue = sb.id_valid & ~sb.flush & ~stall & sb.id_long;

   always_comb begin
      set_vec = '0;
      if (issue && sb.id_rd != '0) set_vec[sb.id_rd] = 1'b1;
      // Set is ORed in after the clear so a same-register reissue stays pending.
      pending_d = (pending_q & ~clr) | set_vec;

      wb_underflow = sb.wb_valid && (cnt_q == '0);
      wb_orphan    = sb.wb_valid && (sb.wb_rd != '0) && !pending_q[sb.wb_rd];
      wb_dec       = sb.wb_valid && !wb_underflow;

      cnt_d = cnt_q;
      if (issue && !wb_dec)      cnt_d = cnt_q + IFL_W'(1);
      else if (!issue && wb_dec) cnt_d = cnt_q - IFL_W'(1);

      err_d = err_q | wb_underflow | wb_orphan;
      stc_d = (stall && stc_q != '1) ? stc_q + CNT_W'(1) : stc_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         stc_q     <= '0;
      end else begin
         pending_q <= pending_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         stc_q     <= stc_d;
      end
   end

   assign sb.stall        = stall;
   assign sb.pc_write     = ~stall;
   assign sb.if_id_write  = ~stall;
   assign sb.id_ex_bubble = stall | sb.flush;
   assign sb.pending      = pending_q;
   assign sb.inflight_cnt = cnt_q;
   assign sb.proto_err    = err_q;
   assign sb.stall_cycles = stc_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: dut0 bypasses WB (CNT_W=16), dut1 does not (CNT_W=4 for a short saturation run).
// Both see identical stimulus; inputs change 1ns after posedge, outputs are checked mid-cycle.
module tb_hazard_scoreboard;
   logic        clk;
   logic        rst_n;
   logic        id_valid;
   logic [9:0]  id_rs;
   logic [1:0]  id_rs_used;
   logic [4:0]  id_rd;
   logic        id_long;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic        flush;

   int n_vec = 0;
   int n_err = 0;

   hazard_scoreboard_if #(.CNT_W(16)) if0 ();
   hazard_scoreboard_if #(.CNT_W(4))  if1 ();

   assign if0.id_valid   = id_valid;
   assign if0.id_rs      = id_rs;
   assign if0.id_rs_used = id_rs_used;
   assign if0.id_rd      = id_rd;
   assign if0.id_long    = id_long;
   assign if0.wb_valid   = wb_valid;
   assign if0.wb_rd      = wb_rd;
   assign if0.flush      = flush;
   assign if1.id_valid   = id_valid;
   assign if1.id_rs      = id_rs;
   assign if1.id_rs_used = id_rs_used;
   assign if1.id_rd      = id_rd;
   assign if1.id_long    = id_long;
   assign if1.wb_valid   = wb_valid;
   assign if1.wb_rd      = wb_rd;
   assign if1.flush      = flush;

   hazard_scoreboard #(.FWD_FROM_WB(1), .CNT_W(16)) u_dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .sb    (if0.slave)
   );

   hazard_scoreboard #(.FWD_FROM_WB(0), .CNT_W(4)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .sb    (if1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                         input logic [1:0] used, input logic [4:0] rd, input logic lng);
      id_valid   = v;
      id_rs      = {rs1, rs0};
      id_rs_used = used;
      id_rd      = rd;
      id_long    = lng;
   endtask

   task automatic set_wb(input logic v, input logic [4:0] rd);
      wb_valid = v;
      wb_rd    = rd;
   endtask

   task automatic do_reset();
      set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0);
      set_wb(1'b0, 5'd0);
      flush = 1'b0;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0);
      set_wb(1'b0, 5'd0);
      tick();
      #2;
      chk("rst_pending",  if0.pending, 32'd0);
      chk("rst_inflight", 32'(if0.inflight_cnt), 32'd0);
      chk("rst_stall",    32'(if0.stall), 32'd0);
      chk("rst_pc_write", 32'(if0.pc_write), 32'd1);
      chk("rst_if_id_wr", 32'(if0.if_id_write), 32'd1);
      chk("rst_err",      32'(if0.proto_err), 32'd0);
      chk("rst_stc",      32'(if0.stall_cycles), 32'd0);
      rst_n = 1'b1;
      tick();

      // load-use: load x5 at c0, add reads x5 from c1, wb x5 at c3
      set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1);
      #2 chk("lu_c0_stall", 32'(if0.stall), 32'd0);
      tick();
      set_id(1'b1, 5'd5, 5'd0, 2'b01, 5'd6, 1'b0);
      #2;
      chk("lu_c1_pend5",  32'(if0.pending[5]), 32'd1);
      chk("lu_c1_stall0", 32'(if0.stall), 32'd1);
      chk("lu_c1_stall1", 32'(if1.stall), 32'd1);
      chk("lu_c1_pcw",    32'(if0.pc_write), 32'd0);
      chk("lu_c1_bubble", 32'(if0.id_ex_bubble), 32'd1);
      chk("lu_c1_ifl",    32'(if0.inflight_cnt), 32'd1);
      tick();
      #2 chk("lu_c2_stall0", 32'(if0.stall), 32'd1);
      tick();
      set_wb(1'b1, 5'd5);
      #2;
      chk("lu_c3_stall0", 32'(if0.stall), 32'd0);
      chk("lu_c3_stall1", 32'(if1.stall), 32'd1);
      chk("lu_c3_pend5",  32'(if0.pending[5]), 32'd1);
      tick();
      set_wb(1'b0, 5'd0);
      #2;
      chk("lu_c4_pend5",  32'(if0.pending[5]), 32'd0);
      chk("lu_c4_stall1", 32'(if1.stall), 32'd0);
      chk("lu_c4_stc0",   32'(if0.stall_cycles), 32'd2);
      chk("lu_c4_stc1",   32'(if1.stall_cycles), 32'd3);
      chk("lu_c4_ifl",    32'(if0.inflight_cnt), 32'd0);
      tick();

      // WAW on x7, then an rd=0 load
      set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1);
      tick();
      #2 chk("waw_stall", 32'(if0.stall), 32'd1);
      tick();
      set_wb(1'b1, 5'd7);
      #2 chk("waw_wb_stall", 32'(if0.stall), 32'd0);
      tick();
      set_wb(1'b0, 5'd0);
      set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1);
      #2;
      chk("waw_pend7", 32'(if0.pending[7]), 32'd1);
      chk("waw_ifl",   32'(if0.inflight_cnt), 32'd1);
      chk("x0_stall",  32'(if0.stall), 32'd0);
      tick();
      set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0);
      #2;
      chk("x0_pending", if0.pending, 32'h0000_0080);
      chk("x0_ifl",     32'(if0.inflight_cnt), 32'd2);
      set_wb(1'b1, 5'd7);
      tick();
      set_wb(1'b1, 5'd0);
      tick();
      set_wb(1'b0, 5'd0);
      #2;
      chk("drain_ifl", 32'(if0.inflight_cnt), 32'd0);
      chk("drain_pnd", if0.pending, 32'd0);
      chk("drain_err", 32'(if0.proto_err), 32'd0);

      // capacity: four loads to x1..x4, fifth to x9
      do_reset();
      for (int r = 1; r <= 4; r++) begin
         set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'(r), 1'b1);
         tick();
      end
      set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1);
      #2;
      chk("cap_stall", 32'(if0.stall), 32'd1);
      chk("cap_ifl",   32'(if0.inflight_cnt), 32'd4);
      tick();
      set_wb(1'b1, 5'd1);
      #2 chk("cap_wb_stall", 32'(if0.stall), 32'd0);
      tick();
      set_wb(1'b0, 5'd0);
      // flush a long op that depends on x2
      set_id(1'b1, 5'd2, 5'd0, 2'b01, 5'd10, 1'b1);
      flush = 1'b1;
      #2;
      chk("cap_ifl_after", 32'(if0.inflight_cnt), 32'd4);
      chk("cap_pending",   if0.pending, 32'h0000_021C);
      chk("fl_stall",      32'(if0.stall), 32'd0);
      chk("fl_bubble",     32'(if0.id_ex_bubble), 32'd1);
      chk("fl_pcw",        32'(if0.pc_write), 32'd1);
      tick();
      flush = 1'b0;
      #2;
      chk("fl_pending", if0.pending, 32'h0000_021C);
      chk("fl_ifl",     32'(if0.inflight_cnt), 32'd4);
      chk("nofl_stall", 32'(if0.stall), 32'd1);
      set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0);

      // writeback to a register that is not pending
      set_wb(1'b1, 5'd5);
      tick();
      set_wb(1'b0, 5'd0);
      #2;
      chk("orphan_err", 32'(if0.proto_err), 32'd1);
      chk("orphan_ifl", 32'(if0.inflight_cnt), 32'd3);

      // writeback with nothing outstanding
      do_reset();
      set_wb(1'b1, 5'd0);
      tick();
      set_wb(1'b0, 5'd0);
      #2;
      chk("uflow_err", 32'(if0.proto_err), 32'd1);
      chk("uflow_ifl", 32'(if0.inflight_cnt), 32'd0);

      // 19 stall cycles: dut1's 4-bit counter saturates at 15
      set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1);
      tick();
      set_id(1'b1, 5'd0, 5'd3, 2'b10, 5'd8, 1'b0);
      for (int i = 0; i < 19; i++) tick();
      #2;
      chk("sat_stc1",  32'(if1.stall_cycles), 32'h0000_000F);
      chk("sat_stc0",  32'(if0.stall_cycles), 32'd19);
      chk("sat_stall", 32'(if0.stall), 32'd1);

      // async reset mid-stall, sampled before the next clock edge
      rst_n = 1'b0;
      #1;
      chk("arst_pending", if0.pending, 32'd0);
      chk("arst_ifl",     32'(if0.inflight_cnt), 32'd0);
      chk("arst_err",     32'(if0.proto_err), 32'd0);
      chk("arst_stc0",    32'(if0.stall_cycles), 32'd0);
      chk("arst_stc1",    32'(if1.stall_cycles), 32'd0);
      chk("arst_stall",   32'(if0.stall), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
